// File: rtl/alu_issue_ctrl.sv
// Issue sequencer in front of the 8-bit combinational ALU: accepts one instruction,
// reads two operands from a small register file, drives the ALU and writes the result back.
module alu_issue_ctrl #(
  parameter int DW   = 8,
  parameter int NREG = 4,
  parameter int AW   = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              rst,
  // valid/ready: an instruction transfers on a rising edge where instr_valid and
  // instr_ready are both 1; upstream holds instr stable while instr_ready is 0.
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [3+3*AW-1:0] instr,
  input  logic              ext_wr_en,
  input  logic [AW-1:0]     ext_wr_addr,
  input  logic [DW-1:0]     ext_wr_data,
  output logic [2:0]        alu_operation,
  output logic [DW-1:0]     alu_a,
  output logic [DW-1:0]     alu_b,
  input  logic [DW-1:0]     alu_result,
  output logic              done,
  output logic [DW-1:0]     result_out,
  output logic              div_zero,
  output logic              err_sticky,
  output logic [1:0]        state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_EXEC = 2'd2,
    S_WB   = 2'd3
  } state_t;

  localparam logic [2:0] OP_DIV = 3'b010;

  state_t            state;
  state_t            state_nx;
  logic [3+3*AW-1:0] instr_q;
  logic [DW-1:0]     regs [NREG];
  logic [DW-1:0]     res_q;
  logic              dz_armed;
  logic              accept;

  logic [2:0]    op_q;
  logic [AW-1:0] dst_q;
  logic [AW-1:0] srca_q;
  logic [AW-1:0] srcb_q;

  assign op_q   = instr_q[3+3*AW-1 -: 3];
  assign dst_q  = instr_q[3*AW-1 -: AW];
  assign srca_q = instr_q[2*AW-1 -: AW];
  assign srcb_q = instr_q[AW-1:0];
  assign accept = instr_valid && instr_ready;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (accept) state_nx = S_READ;
      S_READ:  state_nx = S_EXEC;
      S_EXEC:  state_nx = S_WB;
      S_WB:    state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    instr_ready = (state == S_IDLE) && !rst;
    state_dbg   = state;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
      instr_q       <= '0;
      alu_operation <= '0;
      alu_a         <= '0;
      alu_b         <= '0;
      res_q         <= '0;
      dz_armed      <= 1'b0;
      result_out    <= '0;
      done          <= 1'b0;
      div_zero      <= 1'b0;
      err_sticky    <= 1'b0;
    end else begin
      done     <= 1'b0;
      div_zero <= 1'b0;
      // A writeback to the same register takes priority over the external port.
      if (ext_wr_en && !(state == S_WB && ext_wr_addr == dst_q))
        regs[ext_wr_addr] <= ext_wr_data;
      case (state)
        S_IDLE: if (accept) instr_q <= instr;
        S_READ: begin
          alu_operation <= op_q;
          alu_a         <= regs[srca_q];
          alu_b         <= regs[srcb_q];
        end
        S_EXEC: begin
          if (alu_operation == OP_DIV && alu_b == '0) begin
            res_q    <= '1;
            dz_armed <= 1'b1;
          end else begin
            res_q    <= alu_result;
            dz_armed <= 1'b0;
          end
        end
        S_WB: begin
          regs[dst_q] <= res_q;
          result_out  <= res_q;
          done        <= 1'b1;
          div_zero    <= dz_armed;
          if (dz_armed) err_sticky <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl with a behavioural ALU and a register-file
// reference model; outputs are sampled on the falling edge, inputs driven there too.
module tb_alu_issue_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       instr_valid;
  logic       instr_ready;
  logic [8:0] instr;
  logic       ext_wr_en;
  logic [1:0] ext_wr_addr;
  logic [7:0] ext_wr_data;
  logic [2:0] alu_operation;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [7:0] alu_result;
  logic       done;
  logic [7:0] result_out;
  logic       div_zero;
  logic       err_sticky;
  logic [1:0] state_dbg;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] model [4];
  logic       err_exp;

  always #5 clk = ~clk;

  alu_issue_ctrl dut (
    .clk(clk), .rst(rst),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .ext_wr_en(ext_wr_en), .ext_wr_addr(ext_wr_addr), .ext_wr_data(ext_wr_data),
    .alu_operation(alu_operation), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result),
    .done(done), .result_out(result_out), .div_zero(div_zero), .err_sticky(err_sticky),
    .state_dbg(state_dbg)
  );

  // Combinational ALU; its divide-by-zero output is deliberately not 8'hFF.
  always_comb begin
    case (alu_operation)
      3'b000:  alu_result = alu_a + alu_b;
      3'b001:  alu_result = alu_a - alu_b;
      3'b010:  alu_result = (alu_b == 8'd0) ? 8'h00 : alu_a / alu_b;
      3'b011:  alu_result = alu_a * alu_b;
      3'b100:  alu_result = alu_a & alu_b;
      3'b101:  alu_result = alu_a | alu_b;
      3'b110:  alu_result = ~alu_a;
      default: alu_result = alu_a ^ alu_b;
    endcase
  end

  function automatic logic [7:0] ref_result(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    int r;
    case (op)
      3'd0: r = int'(a) + int'(b);
      3'd1: r = int'(a) - int'(b);
      3'd2: r = (b == 0) ? 255 : int'(a) / int'(b);
      3'd3: r = int'(a) * int'(b);
      3'd4: r = int'(a & b);
      3'd5: r = int'(a | b);
      3'd6: r = 255 - int'(a);
      default: r = int'(a ^ b);
    endcase
    return 8'(r % 256);
  endfunction

  task automatic ext_write(input logic [1:0] addr, input logic [7:0] data);
    @(negedge clk);
    ext_wr_en = 1'b1; ext_wr_addr = addr; ext_wr_data = data;
    @(negedge clk);
    ext_wr_en = 1'b0;
    model[addr] = data;
  endtask

  // ext_mode: 0 none, 1 external write during READ, 2 external write during WB.
  task automatic run_instr(input logic [2:0] op, input logic [1:0] dst, input logic [1:0] sa,
                           input logic [1:0] sb, input int ext_mode, input logic [1:0] ea,
                           input logic [7:0] ed, input string tag);
    logic [7:0] a, b, exp_r;
    logic       dz;
    int         waitc;
    a = model[sa]; b = model[sb];
    exp_r = ref_result(op, a, b);
    dz = (op == 3'd2) && (b == 8'd0);
    @(negedge clk);
    instr_valid = 1'b1; instr = {op, dst, sa, sb};
    waitc = 0;
    while (!instr_ready && waitc < 20) begin @(negedge clk); waitc++; end
    n_vec++;
    if (!instr_ready) begin
      $display("FAIL %s accept timeout: instr_ready=%0b required 1", tag, instr_ready);
      n_err++; instr_valid = 1'b0; return;
    end
    @(negedge clk);
    instr_valid = 1'b0;
    if (ext_mode == 1) begin ext_wr_en = 1'b1; ext_wr_addr = ea; ext_wr_data = ed; end
    n_vec++;
    if (instr_ready !== 1'b0 || done !== 1'b0) begin
      $display("FAIL %s busy c1: ready=%0b done=%0b required 0 0", tag, instr_ready, done); n_err++;
    end
    @(negedge clk);
    ext_wr_en = 1'b0;
    if (ext_mode == 1) model[ea] = ed;
    n_vec++;
    if (alu_operation !== op || alu_a !== a || alu_b !== b || done !== 1'b0) begin
      $display("FAIL %s alu drive: op=%0d a=%h b=%h done=%0b required %0d %h %h 0",
               tag, alu_operation, alu_a, alu_b, done, op, a, b); n_err++;
    end
    @(negedge clk);
    if (ext_mode == 2) begin ext_wr_en = 1'b1; ext_wr_addr = ea; ext_wr_data = ed; end
    n_vec++;
    if (done !== 1'b0) begin
      $display("FAIL %s early done: done=%0b required 0", tag, done); n_err++;
    end
    @(negedge clk);
    ext_wr_en = 1'b0;
    if (ext_mode == 2 && ea != dst) model[ea] = ed;
    model[dst] = exp_r;
    err_exp = err_exp | dz;
    n_vec++;
    if (done !== 1'b1 || result_out !== exp_r || div_zero !== dz || err_sticky !== err_exp) begin
      $display("FAIL %s writeback: done=%0b result=%h dz=%0b sticky=%0b required 1 %h %0b %0b",
               tag, done, result_out, div_zero, err_sticky, exp_r, dz, err_exp); n_err++;
    end
    @(negedge clk);
    n_vec++;
    if (done !== 1'b0 || div_zero !== 1'b0 || result_out !== exp_r || instr_ready !== 1'b1) begin
      $display("FAIL %s post pulse: done=%0b dz=%0b result=%h ready=%0b required 0 0 %h 1",
               tag, done, div_zero, result_out, instr_ready, exp_r); n_err++;
    end
  endtask

  // Reads a register by OR-ing it with itself back into itself.
  task automatic read_reg(input logic [1:0] r, input string tag);
    run_instr(3'd5, r, r, r, 0, 2'd0, 8'd0, tag);
  endtask

  task automatic test_reset;
    rst = 1'b1; instr_valid = 1'b0; instr = '0; ext_wr_en = 1'b0; ext_wr_addr = '0; ext_wr_data = '0;
    for (int i = 0; i < 4; i++) model[i] = 8'd0;
    err_exp = 1'b0;
    @(negedge clk); @(negedge clk);
    n_vec++;
    if (instr_ready !== 1'b0) begin
      $display("FAIL reset_ready_low: instr_ready=%0b required 0", instr_ready); n_err++;
    end
    rst = 1'b0;
    @(negedge clk);
    n_vec++;
    if (instr_ready !== 1'b1 || done !== 1'b0 || div_zero !== 1'b0 || err_sticky !== 1'b0 ||
        result_out !== 8'd0 || alu_operation !== 3'd0 || alu_a !== 8'd0 || alu_b !== 8'd0) begin
      $display("FAIL reset_values: ready=%0b done=%0b dz=%0b sticky=%0b res=%h op=%0d a=%h b=%h required 1 0 0 0 00 0 00 00",
               instr_ready, done, div_zero, err_sticky, result_out, alu_operation, alu_a, alu_b); n_err++;
    end
  endtask

  task automatic test_add;
    ext_write(2'd0, 8'd25);
    ext_write(2'd1, 8'd17);
    run_instr(3'd0, 2'd2, 2'd0, 2'd1, 0, 2'd0, 8'd0, "add");
    read_reg(2'd2, "add_r2");
  endtask

  task automatic test_mul_sub;
    ext_write(2'd0, 8'd20);
    ext_write(2'd1, 8'd13);
    run_instr(3'd3, 2'd3, 2'd0, 2'd1, 0, 2'd0, 8'd0, "mul_wrap");
    run_instr(3'd1, 2'd0, 2'd1, 2'd0, 0, 2'd0, 8'd0, "sub_neg");
  endtask

  task automatic test_div;
    ext_write(2'd0, 8'd77);
    ext_write(2'd1, 8'd0);
    run_instr(3'd2, 2'd2, 2'd0, 2'd1, 0, 2'd0, 8'd0, "div_zero");
    ext_write(2'd0, 8'd100);
    ext_write(2'd1, 8'd7);
    run_instr(3'd2, 2'd3, 2'd0, 2'd1, 0, 2'd0, 8'd0, "div_ok");
  endtask

  task automatic test_back_to_back;
    logic [8:0] prog [3];
    logic [7:0] exp_q [$];
    int         done_q [$];
    int         idx = 0;
    int         last_acc = -100;
    prog[0] = {3'd0, 2'd2, 2'd0, 2'd1};
    prog[1] = {3'd7, 2'd3, 2'd2, 2'd0};
    prog[2] = {3'd1, 2'd0, 2'd3, 2'd1};
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (done_q.size() > 0 && done_q[0] == t) begin
        logic [7:0] e;
        void'(done_q.pop_front());
        e = exp_q.pop_front();
        n_vec++;
        if (done !== 1'b1 || result_out !== e) begin
          $display("FAIL b2b_done t=%0d: done=%0b result=%h required 1 %h", t, done, result_out, e); n_err++;
        end
      end else begin
        n_vec++;
        if (done !== 1'b0) begin
          $display("FAIL b2b_spurious_done t=%0d: done=%0b required 0", t, done); n_err++;
        end
      end
      if (idx < 3) begin
        instr_valid = 1'b1; instr = prog[idx];
        if (idx > 0 && t - last_acc < 4) begin
          n_vec++;
          if (instr_ready !== 1'b0) begin
            $display("FAIL b2b_ready_low t=%0d: instr_ready=%0b required 0", t, instr_ready); n_err++;
          end
        end
        if (instr_ready === 1'b1) begin
          logic [2:0] op;
          logic [1:0] d, sa, sb;
          logic [7:0] r;
          if (idx > 0) begin
            n_vec++;
            if (t - last_acc != 4) begin
              $display("FAIL b2b_spacing: gap=%0d required 4", t - last_acc); n_err++;
            end
          end
          {op, d, sa, sb} = prog[idx];
          r = ref_result(op, model[sa], model[sb]);
          model[d] = r;
          exp_q.push_back(r);
          done_q.push_back(t + 4);
          last_acc = t;
          idx++;
        end
      end else begin
        instr_valid = 1'b0;
      end
    end
    n_vec++;
    if (done_q.size() != 0 || idx != 3) begin
      $display("FAIL b2b_complete: accepted=%0d pending_done=%0d required 3 0", idx, done_q.size()); n_err++;
    end
  endtask

  task automatic test_ext_collision;
    ext_write(2'd0, 8'd9);
    ext_write(2'd3, 8'd4);
    run_instr(3'd0, 2'd1, 2'd0, 2'd3, 2, 2'd1, 8'hAA, "wb_wins");
    read_reg(2'd1, "wb_wins_r1");
    run_instr(3'd4, 2'd1, 2'd0, 2'd0, 2, 2'd2, 8'hAA, "both_write");
    read_reg(2'd1, "both_r1");
    read_reg(2'd2, "both_r2");
  endtask

  task automatic test_ext_in_read;
    ext_write(2'd0, 8'd50);
    ext_write(2'd1, 8'd8);
    run_instr(3'd1, 2'd2, 2'd0, 2'd1, 1, 2'd0, 8'd3, "read_old");
    read_reg(2'd0, "read_old_r0");
  endtask

  task automatic test_random;
    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 3) == 0)
        ext_write(2'($urandom_range(0, 3)), ($urandom_range(0, 2) == 0) ? 8'd0 : 8'($urandom));
      run_instr(3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                2'($urandom_range(0, 3)), int'($urandom_range(0, 2)), 2'($urandom_range(0, 3)),
                8'($urandom), "random");
    end
  endtask

  task automatic test_mid_reset;
    ext_write(2'd0, 8'd5);
    ext_write(2'd1, 8'd6);
    ext_write(2'd2, 8'd7);
    ext_write(2'd3, 8'd8);
    @(negedge clk);
    instr_valid = 1'b1; instr = {3'd0, 2'd3, 2'd0, 2'd1};
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_vec++;
    if (instr_ready !== 1'b0 || done !== 1'b0) begin
      $display("FAIL midrst_during: ready=%0b done=%0b required 0 0", instr_ready, done); n_err++;
    end
    rst = 1'b0;
    for (int i = 0; i < 4; i++) model[i] = 8'd0;
    err_exp = 1'b0;
    @(negedge clk);
    n_vec++;
    if (instr_ready !== 1'b1 || done !== 1'b0 || err_sticky !== 1'b0 || result_out !== 8'd0) begin
      $display("FAIL midrst_after: ready=%0b done=%0b sticky=%0b res=%h required 1 0 0 00",
               instr_ready, done, err_sticky, result_out); n_err++;
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_vec++;
      if (done !== 1'b0) begin
        $display("FAIL midrst_no_done: done=%0b required 0", done); n_err++;
      end
    end
    for (int r = 0; r < 4; r++) read_reg(2'(r), "midrst_reg_clear");
  endtask

  initial begin
    test_reset();
    test_add();
    test_mul_sub();
    test_div();
    test_back_to_back();
    test_ext_collision();
    test_ext_in_read();
    test_random();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/alu_issue_ctrl.md
# alu_issue_ctrl

Sequencer placed directly upstream of the 8-bit combinational ALU. It accepts instruction words over a valid/ready handshake and reads two operands from a small internal register file. It drives the ALU's `operation`/`OperandA`/`OperandB` inputs, captures the ALU `result`, and writes it back to a destination register. Completion is signalled with a pulse, and divide-by-zero is flagged.

## Interface
- `DW`, 8, data width; must match ALU operand width
- `NREG`, 4, register-file entries; `AW = $clog2(NREG)` = 2
- `clk`  in  1  rising-edge clock
- `rst`  in  1  synchronous, active-high reset
- `instr_valid`  in  1  instruction offered
- `instr_ready`  out  1  controller idle, can accept
- `instr`  in  3+3*AW (9)  `[8:6]` op, `[5:4]` dst, `[3:2]` srca, `[1:0]` srcb
- `ext_wr_en`  in  1  external register load
- `ext_wr_addr`  in  AW  load address
- `ext_wr_data`  in  DW  load data
- `alu_operation`  out  3  to ALU `operation`
- `alu_a`  out  DW  to ALU `OperandA`
- `alu_b`  out  DW  to ALU `OperandB`
- `alu_result`  in  DW  from ALU `result`
- `done`  out  1  one-cycle pulse on writeback
- `result_out`  out  DW  value written back; held until next writeback
- `div_zero`  out  1  one-cycle pulse, coincident with `done`
- `err_sticky`  out  1  set by any divide-by-zero; cleared only by `rst`

## Operation
- Opcode map is fixed by the ALU:
  - 000 add, 001 sub, 010 div, 011 mul, 100 and, 101 or, 110 not A, 111 xor.
  - Results are truncated to DW bits.
- FSM states:
  - IDLE: `instr_ready`=1. On `instr_valid`, latch `instr` and go to READ.
  - READ: load `alu_operation`/`alu_a`/`alu_b` registers from the latched op, `regs[srca]` and `regs[srcb]`. Go to EXEC.
  - EXEC: ALU outputs are stable. Capture `alu_result` into the internal result register. Go to WB.
    - Exception: if op=010 and `alu_b`==0, capture 8'hFF instead and arm `div_zero`.
  - WB: write the captured value to `regs[dst]` and `result_out`. Pulse `done`, plus `div_zero` if armed. Set `err_sticky` if armed. Go to IDLE.
- `alu_*` outputs hold their last values in IDLE; they do not return to zero.
- `instr_ready` is 0 in READ, EXEC and WB. Instructions offered then are not accepted; upstream must hold them.
- External load port:
  - `ext_wr_en` writes `regs[ext_wr_addr]` in any state.
  - In the same cycle as a WB to the same address, the WB write wins and the external write is dropped. Different addresses both write.
  - An external write in READ to a source register is not seen by that instruction: the register file is read at the clock edge that ends READ. Reads see pre-write contents (write-first is not used).
- srca == srcb, and dst equal to a source, are legal. The source values are read in READ, before WB.

## Timing
- Accept edge = cycle 0 (`instr_valid && instr_ready` at a rising edge).
- Cycle 1: `alu_*` valid.
- Cycle 2: result captured.
- Cycle 3: `done`, `result_out`, `div_zero` asserted and the register file updated.
- Back-to-back throughput is one instruction per 4 cycles. The next accept edge can be cycle 4 at the earliest, because `instr_ready` returns at cycle 4.
- Reset values:
  - State IDLE; `instr_ready` 0 during the reset cycle and 1 on the first cycle after `rst` deasserts.
  - All `regs`, `alu_operation`, `alu_a`, `alu_b`, `result_out` = 0.
  - `done`, `div_zero`, `err_sticky` = 0.
- `rst` mid-instruction aborts it. No writeback and no `done` occur, and the register file is cleared.

## Test plan
- Load r0=8'd25, r1=8'd17 via the external port. Issue add dst=r2 (instr 9'b000_10_00_01). Required: `done` exactly 3 cycles after accept, `result_out`=8'd42, r2=42.
- r0=8'd20, r1=8'd13, mul dst=r3. Required: `result_out`=8'd4 (260 mod 256). Then sub r1-r0 into r0: required 8'hF9.
- div r0/r1 with r1=0. Required: `result_out`=8'hFF, `div_zero` and `done` on the same cycle, `err_sticky` stays 1 afterwards. A later valid div 8'd100/8'd7 gives 8'd14 with `div_zero`=0 and `err_sticky` still 1.
- Hold `instr_valid` high continuously with 3 instructions. Required: accepts at cycles 0, 4 and 8 only; each `done` at accept+3; `instr_ready` low between accepts.
- During the WB of an instruction with dst=r1, drive `ext_wr_en` to r1 with 8'hAA. Required: r1 holds the ALU result. Repeat with addr r2: both r1 and r2 are updated.
- Assert `rst` at cycle 2 after accept. Required: no `done`, all regs 0, `instr_ready`=1 one cycle after `rst` drops.
